// File: rtl/axis_throttler_decim.sv
// AXI4-Stream decimator: forwards one accepted beat out of every 2^log_throttle through a registered output stage.
// Optional drop counter output is enabled by defining AXIS_THROTTLER_DROP_CNT_EN.
module axis_throttler_decim #(
  parameter int AXIS_TDATA_WIDTH = 32
) (
  input  logic                        aclk,
  input  logic                        areset,
  input  logic [4:0]                  log_throttle,
  input  logic                        S_AXIS_tvalid,
  output logic                        S_AXIS_tready,
  input  logic [AXIS_TDATA_WIDTH-1:0] S_AXIS_tdata,
  output logic                        M_AXIS_tvalid,
  input  logic                        M_AXIS_tready,
  output logic [AXIS_TDATA_WIDTH-1:0] M_AXIS_tdata
`ifdef AXIS_THROTTLER_DROP_CNT_EN
  ,
  output logic [31:0]                 drop_count
`endif
);

  logic [4:0]                  r_log;
  logic [31:0]                 r_cnt;
  logic                        r_valid;
  logic [AXIS_TDATA_WIDTH-1:0] r_data;

  logic                        w_change;
  logic [4:0]                  w_log;
  logic [31:0]                 w_mask;
  logic [31:0]                 w_cntEff;
  logic [31:0]                 w_cntNext;
  logic                        w_accept;
  logic                        w_fwd;

  // An exponent change restarts the phase, so the beat on that edge is seen at count zero.
  assign w_change  = (r_log != log_throttle);
  assign w_log     = w_change ? log_throttle : r_log;
  assign w_mask    = (32'd1 << w_log) - 32'd1;
  assign w_cntEff  = w_change ? 32'd0 : r_cnt;
  assign w_cntNext = (w_cntEff == w_mask) ? 32'd0 : (w_cntEff + 32'd1);

  assign S_AXIS_tready = !areset && (!r_valid || M_AXIS_tready);
  assign w_accept      = S_AXIS_tvalid && S_AXIS_tready;
  assign w_fwd         = w_accept && (w_cntEff == 32'd0);

  assign M_AXIS_tvalid = r_valid;
  assign M_AXIS_tdata  = r_data;

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      r_log   <= 5'd0;
      r_cnt   <= 32'd0;
      r_valid <= 1'b0;
      r_data  <= '0;
    end else begin
      r_log <= log_throttle;

      if (w_accept) begin
        r_cnt <= w_cntNext;
      end else if (w_change) begin
        r_cnt <= 32'd0;
      end

      // A load on the same edge as a drain keeps the stage full with the new beat.
      if (w_fwd) begin
        r_valid <= 1'b1;
        r_data  <= S_AXIS_tdata;
      end else if (M_AXIS_tready) begin
        r_valid <= 1'b0;
      end
    end
  end

`ifdef AXIS_THROTTLER_DROP_CNT_EN
  logic [31:0] r_dropCnt;

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      r_dropCnt <= 32'd0;
    end else if (w_change) begin
      r_dropCnt <= 32'd0;
    end else if (w_accept && !w_fwd && (r_dropCnt != 32'hFFFF_FFFF)) begin
      r_dropCnt <= r_dropCnt + 32'd1;
    end
  end

  assign drop_count = r_dropCnt;
`endif

endmodule

// File: tb/tb_axis_throttler_decim.sv
// Directed self-checking bench for axis_throttler_decim.
// Drop counter checks are included when AXIS_THROTTLER_DROP_CNT_EN is defined.
module tb_axis_throttler_decim;

  logic        aclk = 1'b0;
  logic        areset;
  logic [4:0]  log_throttle;
  logic        S_AXIS_tvalid;
  logic        S_AXIS_tready;
  logic [31:0] S_AXIS_tdata;
  logic        M_AXIS_tvalid;
  logic        M_AXIS_tready;
  logic [31:0] M_AXIS_tdata;
`ifdef AXIS_THROTTLER_DROP_CNT_EN
  logic [31:0] drop_count;
`endif

  int nChecks = 0;
  int nPassed = 0;

  always #5 aclk = ~aclk;

  axis_throttler_decim #(.AXIS_TDATA_WIDTH(32)) dut (
    .aclk          (aclk),
    .areset        (areset),
    .log_throttle  (log_throttle),
    .S_AXIS_tvalid (S_AXIS_tvalid),
    .S_AXIS_tready (S_AXIS_tready),
    .S_AXIS_tdata  (S_AXIS_tdata),
    .M_AXIS_tvalid (M_AXIS_tvalid),
    .M_AXIS_tready (M_AXIS_tready),
    .M_AXIS_tdata  (M_AXIS_tdata)
`ifdef AXIS_THROTTLER_DROP_CNT_EN
    ,
    .drop_count    (drop_count)
`endif
  );

  // Advance to just after the next rising edge, where outputs are sampled and inputs change.
  task automatic cycle();
    @(posedge aclk);
    #1;
  endtask

  task automatic test_reset();
    areset        = 1'b1;
    log_throttle  = 5'd0;
    S_AXIS_tvalid = 1'b0;
    S_AXIS_tdata  = 32'd0;
    M_AXIS_tready = 1'b1;
    repeat (3) cycle();
    nChecks++;
    if (M_AXIS_tvalid !== 1'b0) $display("[TB] FAIL reset_tvalid: got %b expected 0", M_AXIS_tvalid);
    else nPassed++;
    nChecks++;
    if (M_AXIS_tdata !== 32'd0) $display("[TB] FAIL reset_tdata: got %0h expected 0", M_AXIS_tdata);
    else nPassed++;
    nChecks++;
    if (S_AXIS_tready !== 1'b0) $display("[TB] FAIL reset_s_tready: got %b expected 0", S_AXIS_tready);
    else nPassed++;
    areset = 1'b0;
    #1;
    nChecks++;
    if (S_AXIS_tready !== 1'b1) $display("[TB] FAIL post_reset_s_tready: got %b expected 1", S_AXIS_tready);
    else nPassed++;
  endtask

  // N=3, ten beats of value 2: beats #0 and #8 come out.
  task automatic test_decim_n3();
    int outs = 0;
    logic expV;
    log_throttle  = 5'd3;
    M_AXIS_tready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      S_AXIS_tvalid = 1'b1;
      S_AXIS_tdata  = 32'd2;
      #1;
      nChecks++;
      if (S_AXIS_tready !== 1'b1) $display("[TB] FAIL n3_s_tready[%0d]: got %b expected 1", i, S_AXIS_tready);
      else nPassed++;
      cycle();
      expV = (i == 0) || (i == 8);
      nChecks++;
      if (M_AXIS_tvalid !== expV) $display("[TB] FAIL n3_tvalid[%0d]: got %b expected %b", i, M_AXIS_tvalid, expV);
      else nPassed++;
      if (M_AXIS_tvalid === 1'b1) begin
        outs++;
        nChecks++;
        if (M_AXIS_tdata !== 32'd2) $display("[TB] FAIL n3_tdata[%0d]: got %0h expected 2", i, M_AXIS_tdata);
        else nPassed++;
      end
    end
    S_AXIS_tvalid = 1'b0;
    cycle();
    nChecks++;
    if (outs != 2) $display("[TB] FAIL n3_out_count: got %0d expected 2", outs);
    else nPassed++;
    nChecks++;
    if (M_AXIS_tvalid !== 1'b0) $display("[TB] FAIL n3_drain: got %b expected 0", M_AXIS_tvalid);
    else nPassed++;
  endtask

  // N=0 pass-through, one beat per cycle, 1-cycle latency.
  task automatic test_back_to_back();
    log_throttle  = 5'd0;
    S_AXIS_tvalid = 1'b0;
    cycle();
    for (int i = 0; i < 16; i++) begin
      S_AXIS_tvalid = 1'b1;
      S_AXIS_tdata  = 32'(i);
      cycle();
      nChecks++;
      if (M_AXIS_tvalid !== 1'b1 || M_AXIS_tdata !== 32'(i))
        $display("[TB] FAIL b2b[%0d]: got v=%b d=%0h expected v=1 d=%0h", i, M_AXIS_tvalid, M_AXIS_tdata, i);
      else nPassed++;
    end
    S_AXIS_tvalid = 1'b0;
    cycle();
    nChecks++;
    if (M_AXIS_tvalid !== 1'b0) $display("[TB] FAIL b2b_drain: got %b expected 0", M_AXIS_tvalid);
    else nPassed++;
  endtask

  // N=2 with the output stalled: input stalls, data holds, phase survives.
  task automatic test_backpressure();
    logic expV;
    log_throttle  = 5'd2;
    S_AXIS_tvalid = 1'b0;
    cycle();
    M_AXIS_tready = 1'b0;
    S_AXIS_tvalid = 1'b1;
    S_AXIS_tdata  = 32'd100;
    cycle();
    S_AXIS_tdata  = 32'd101;
    for (int i = 0; i < 3; i++) begin
      nChecks++;
      if (M_AXIS_tvalid !== 1'b1 || M_AXIS_tdata !== 32'd100 || S_AXIS_tready !== 1'b0)
        $display("[TB] FAIL bp_stall[%0d]: got v=%b d=%0h srdy=%b expected v=1 d=64 srdy=0",
                 i, M_AXIS_tvalid, M_AXIS_tdata, S_AXIS_tready);
      else nPassed++;
      cycle();
    end
    M_AXIS_tready = 1'b1;
    #1;
    nChecks++;
    if (S_AXIS_tready !== 1'b1) $display("[TB] FAIL bp_release_s_tready: got %b expected 1", S_AXIS_tready);
    else nPassed++;
    for (int i = 1; i <= 4; i++) begin
      S_AXIS_tdata = 32'(100 + i);
      cycle();
      expV = (i == 4);
      nChecks++;
      if (M_AXIS_tvalid !== expV) $display("[TB] FAIL bp_phase_tvalid[%0d]: got %b expected %b", i, M_AXIS_tvalid, expV);
      else nPassed++;
    end
    nChecks++;
    if (M_AXIS_tdata !== 32'd104) $display("[TB] FAIL bp_phase_tdata: got %0d expected 104", M_AXIS_tdata);
    else nPassed++;
    S_AXIS_tvalid = 1'b0;
    cycle();
  endtask

  // Exponent 3 -> 1 mid-stream: change-edge beat forwarded, then every second beat.
  task automatic test_change();
    logic        expV;
    logic [31:0] expD;
    log_throttle  = 5'd3;
    S_AXIS_tvalid = 1'b0;
    cycle();
    for (int i = 0; i < 8; i++) begin
      if (i == 3) log_throttle = 5'd1;
      S_AXIS_tvalid = 1'b1;
      S_AXIS_tdata  = 32'(200 + i);
      cycle();
      expV = (i == 0) || (i == 3) || (i == 5) || (i == 7);
      expD = expV ? 32'(200 + i) : M_AXIS_tdata;
      nChecks++;
      if (M_AXIS_tvalid !== expV || (expV && M_AXIS_tdata !== expD))
        $display("[TB] FAIL chg[%0d]: got v=%b d=%0d expected v=%b d=%0d", i, M_AXIS_tvalid, M_AXIS_tdata, expV, 200 + i);
      else nPassed++;
    end
    S_AXIS_tvalid = 1'b0;
    cycle();
  endtask

  // Reset asserted with a pending beat clears outputs without any clock edge.
  task automatic test_reset_midstream();
    log_throttle  = 5'd0;
    S_AXIS_tvalid = 1'b0;
    cycle();
    S_AXIS_tvalid = 1'b1;
    S_AXIS_tdata  = 32'd55;
    cycle();
    M_AXIS_tready = 1'b0;
    S_AXIS_tvalid = 1'b0;
    #1;
    nChecks++;
    if (M_AXIS_tvalid !== 1'b1 || M_AXIS_tdata !== 32'd55)
      $display("[TB] FAIL rstmid_pending: got v=%b d=%0d expected v=1 d=55", M_AXIS_tvalid, M_AXIS_tdata);
    else nPassed++;
    areset = 1'b1;
    #1;
    nChecks++;
    if (M_AXIS_tvalid !== 1'b0 || M_AXIS_tdata !== 32'd0 || S_AXIS_tready !== 1'b0)
      $display("[TB] FAIL rstmid_async: got v=%b d=%0d srdy=%b expected v=0 d=0 srdy=0",
               M_AXIS_tvalid, M_AXIS_tdata, S_AXIS_tready);
    else nPassed++;
    cycle();
    areset        = 1'b0;
    log_throttle  = 5'd2;
    M_AXIS_tready = 1'b1;
    S_AXIS_tvalid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      S_AXIS_tdata = 32'(77 + i);
      cycle();
      nChecks++;
      if (M_AXIS_tvalid !== ((i == 0) || (i == 4)))
        $display("[TB] FAIL rstmid_after[%0d]: got v=%b expected %b", i, M_AXIS_tvalid, (i == 0) || (i == 4));
      else nPassed++;
    end
    nChecks++;
    if (M_AXIS_tdata !== 32'd81) $display("[TB] FAIL rstmid_tdata: got %0d expected 81", M_AXIS_tdata);
    else nPassed++;
    S_AXIS_tvalid = 1'b0;
    cycle();
  endtask

`ifdef AXIS_THROTTLER_DROP_CNT_EN
  // N=2, twelve beats: three forwarded, nine dropped.
  task automatic test_drop_count();
    int outs = 0;
    log_throttle  = 5'd3;
    S_AXIS_tvalid = 1'b0;
    cycle();
    log_throttle = 5'd2;
    cycle();
    nChecks++;
    if (drop_count !== 32'd0) $display("[TB] FAIL drop_clear: got %0d expected 0", drop_count);
    else nPassed++;
    for (int i = 0; i < 12; i++) begin
      S_AXIS_tvalid = 1'b1;
      S_AXIS_tdata  = 32'(300 + i);
      cycle();
      if (M_AXIS_tvalid === 1'b1) outs++;
    end
    S_AXIS_tvalid = 1'b0;
    cycle();
    nChecks++;
    if (outs != 3) $display("[TB] FAIL drop_fwd_count: got %0d expected 3", outs);
    else nPassed++;
    nChecks++;
    if (drop_count !== 32'd9) $display("[TB] FAIL drop_count: got %0d expected 9", drop_count);
    else nPassed++;
  endtask
`endif

  initial begin
    test_reset();
    test_decim_n3();
    test_back_to_back();
    test_backpressure();
    test_change();
    test_reset_midstream();
`ifdef AXIS_THROTTLER_DROP_CNT_EN
    test_drop_count();
`endif
    $display("%0d/%0d checks passed", nPassed, nChecks);
    $finish;
  end

endmodule
